// File: rtl/rv32i_types.sv
// Shared types for the RV32I front end: NOP encoding, fetch FSM states and the
// buffered fetch entry layout.
package rv32i_types;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO for fetched {pc, instr} entries; flush has priority over
// push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues single outstanding I-cache reads and
// buffers returned words for the instruction register.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0060,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        ir_load
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  redirect_tgt;
  logic         push;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head_entry;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign push_entry   = '{pc: req_addr_q, instr: imem_rdata};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (!fifo_full) begin
          req_addr_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          if (redirect_valid) begin
            pc_d = redirect_tgt;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
          state_d = IDLE;
        end else if (redirect_valid) begin
          // The cache cannot abort, so keep the request up and drop its data later.
          pc_d    = redirect_tgt;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (ir_load),
    .flush    (redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_entry)
  );

  assign imem_read    = (state_q != IDLE);
  assign imem_address = req_addr_q;
  assign out_valid    = !fifo_empty;
  assign out_instr    = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc       = out_valid ? head_entry.pc : 32'h0;
  assign ir_load      = out_valid && !stall && !redirect_valid;

endmodule
